// File: rtl/pkt_stat_counter.sv
// Per-port sop-edge packet counters with saturating total, sticky sat flags, clear and coherent snapshot readout.
// Optional per-port beat counters (vld_in) are built only when PKT_STAT_BEAT_EN is defined.
module pkt_stat_counter #(
    parameter int PORT_NUB  = 4,
    parameter int CNT_WIDTH = 16,
    parameter int EDGE_MODE = 0
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [PORT_NUB-1:0]                   sop_in,
    input  logic [PORT_NUB-1:0]                   vld_in,
    input  logic                                  clear,
    input  logic                                  snap,
    input  logic [$clog2(PORT_NUB)-1:0]           rd_sel,
    output logic [CNT_WIDTH-1:0]                  rd_cnt,
    output logic [CNT_WIDTH-1:0]                  rd_beat,
    output logic [CNT_WIDTH+$clog2(PORT_NUB)-1:0] total_cnt,
    output logic [PORT_NUB-1:0]                   sat_flag,
    output logic                                  snap_vld
);
    localparam int SEL_W = $clog2(PORT_NUB);
    localparam int SUM_W = $clog2(PORT_NUB + 1);
    localparam int TOT_W = CNT_WIDTH + SEL_W;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [PORT_NUB-1:0]  r_s0;
    logic [PORT_NUB-1:0]  r_s1;
    logic [PORT_NUB-1:0]  w_edge;
    logic [CNT_WIDTH-1:0] r_cnt [PORT_NUB];
    logic [CNT_WIDTH-1:0] r_shd [PORT_NUB];
    logic [TOT_W-1:0]     r_total;
    logic [TOT_W:0]       w_tot_add;
    logic [SUM_W-1:0]     w_sum;
    logic [PORT_NUB-1:0]  r_sat;
    logic                 r_snap_vld;
    logic [CNT_WIDTH-1:0] r_rd_cnt;
    logic                 w_sel_ok;

    generate
        if (EDGE_MODE == 1) begin : g_fall
            assign w_edge = ~r_s0 & r_s1;
        end else begin : g_rise
            assign w_edge = r_s0 & ~r_s1;
        end

        // Only a non-power-of-2 port count can address a missing port.
        if (PORT_NUB == (2 ** SEL_W)) begin : g_sel_full
            assign w_sel_ok = 1'b1;
        end else begin : g_sel_part
            assign w_sel_ok = (rd_sel < SEL_W'(PORT_NUB));
        end
    endgenerate

    always_comb begin
        w_sum = '0;
        for (int p = 0; p < PORT_NUB; p++) begin
            w_sum = w_sum + SUM_W'(w_edge[p]);
        end
    end

    assign w_tot_add = {1'b0, r_total} + (TOT_W + 1)'(w_sum);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s0       <= '0;
            r_s1       <= '0;
            r_total    <= '0;
            r_sat      <= '0;
            r_snap_vld <= 1'b0;
            r_rd_cnt   <= '0;
            for (int p = 0; p < PORT_NUB; p++) begin
                r_cnt[p] <= '0;
                r_shd[p] <= '0;
            end
        end else begin
            r_s0       <= sop_in;
            r_s1       <= r_s0;
            r_snap_vld <= r_snap_vld | snap;
            r_rd_cnt   <= w_sel_ok ? r_shd[rd_sel] : '0;
            // Shadows take the pre-update counts, so snap+clear loses nothing.
            if (snap) begin
                for (int p = 0; p < PORT_NUB; p++) begin
                    r_shd[p] <= r_cnt[p];
                end
            end
            if (clear) begin
                r_total <= '0;
                r_sat   <= '0;
                for (int p = 0; p < PORT_NUB; p++) begin
                    r_cnt[p] <= '0;
                end
            end else begin
                r_total <= w_tot_add[TOT_W] ? '1 : w_tot_add[TOT_W-1:0];
                for (int p = 0; p < PORT_NUB; p++) begin
                    if (w_edge[p] && (r_cnt[p] != CNT_MAX)) begin
                        r_cnt[p] <= r_cnt[p] + 1'b1;
                    end
                    if (w_edge[p] && (r_cnt[p] >= (CNT_MAX - 1'b1))) begin
                        r_sat[p] <= 1'b1;
                    end
                end
            end
        end
    end

    assign rd_cnt    = r_rd_cnt;
    assign total_cnt = r_total;
    assign sat_flag  = r_sat;
    assign snap_vld  = r_snap_vld;

`ifdef PKT_STAT_BEAT_EN
    logic [PORT_NUB-1:0]  r_v0;
    logic [CNT_WIDTH-1:0] r_beat  [PORT_NUB];
    logic [CNT_WIDTH-1:0] r_bshd  [PORT_NUB];
    logic [CNT_WIDTH-1:0] r_rd_beat;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v0      <= '0;
            r_rd_beat <= '0;
            for (int p = 0; p < PORT_NUB; p++) begin
                r_beat[p] <= '0;
                r_bshd[p] <= '0;
            end
        end else begin
            r_v0      <= vld_in;
            r_rd_beat <= w_sel_ok ? r_bshd[rd_sel] : '0;
            if (snap) begin
                for (int p = 0; p < PORT_NUB; p++) begin
                    r_bshd[p] <= r_beat[p];
                end
            end
            for (int p = 0; p < PORT_NUB; p++) begin
                if (clear) begin
                    r_beat[p] <= '0;
                end else if (r_v0[p] && (r_beat[p] != CNT_MAX)) begin
                    r_beat[p] <= r_beat[p] + 1'b1;
                end
            end
        end
    end

    assign rd_beat = r_rd_beat;
`else
    logic w_unused_vld;
    assign w_unused_vld = ^vld_in;
    assign rd_beat      = '0;
`endif

endmodule

// File: tb/tb_pkt_stat_counter.sv
// Bench for pkt_stat_counter: instance a (defaults), b (CNT_WIDTH=4), c (EDGE_MODE=1) share one stimulus bus.
module tb_pkt_stat_counter;
    logic       clk;
    logic       rst;
    logic [3:0] sop_in;
    logic [3:0] vld_in;
    logic       clear;
    logic       snap;
    logic [1:0] rd_sel;

    logic [15:0] a_rd_cnt, a_rd_beat, c_rd_cnt, c_rd_beat;
    logic [17:0] a_total, c_total;
    logic [3:0]  a_sat, c_sat, b_rd_cnt, b_rd_beat, b_sat;
    logic [5:0]  b_total;
    logic        a_snap_vld, b_snap_vld, c_snap_vld;

    pkt_stat_counter #(.PORT_NUB(4), .CNT_WIDTH(16), .EDGE_MODE(0)) u_a (
        .clk(clk), .rst(rst), .sop_in(sop_in), .vld_in(vld_in), .clear(clear), .snap(snap),
        .rd_sel(rd_sel), .rd_cnt(a_rd_cnt), .rd_beat(a_rd_beat), .total_cnt(a_total),
        .sat_flag(a_sat), .snap_vld(a_snap_vld));

    pkt_stat_counter #(.PORT_NUB(4), .CNT_WIDTH(4), .EDGE_MODE(0)) u_b (
        .clk(clk), .rst(rst), .sop_in(sop_in), .vld_in(vld_in), .clear(clear), .snap(snap),
        .rd_sel(rd_sel), .rd_cnt(b_rd_cnt), .rd_beat(b_rd_beat), .total_cnt(b_total),
        .sat_flag(b_sat), .snap_vld(b_snap_vld));

    pkt_stat_counter #(.PORT_NUB(4), .CNT_WIDTH(16), .EDGE_MODE(1)) u_c (
        .clk(clk), .rst(rst), .sop_in(sop_in), .vld_in(vld_in), .clear(clear), .snap(snap),
        .rd_sel(rd_sel), .rd_cnt(c_rd_cnt), .rd_beat(c_rd_beat), .total_cnt(c_total),
        .sat_flag(c_sat), .snap_vld(c_snap_vld));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] mask;
        int         exp_total;
    } vec_t;

    typedef struct {
        int          id;
        logic [15:0] cnt;
        logic [15:0] beat;
    } rd_exp_t;

    vec_t    tbl [6];
    rd_exp_t sb [$];
    int      n_checks = 0;
    int      n_fail   = 0;
    int      m [4];

`ifdef PKT_STAT_BEAT_EN
    localparam logic [15:0] BEAT_EXP = 16'd10;
`else
    localparam logic [15:0] BEAT_EXP = 16'd0;
`endif

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic pulse(input logic [3:0] mask);
        sop_in = mask;
        step();
        sop_in = 4'b0;
        step();
        step();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic do_snap();
        snap = 1'b1;
        step();
        snap = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Expected readout is queued when rd_sel is driven and retired one edge later.
    task automatic do_read(input int id, input int sel, input logic [15:0] ecnt, input logic [15:0] ebeat);
        rd_exp_t e;
        e.id   = id;
        e.cnt  = ecnt;
        e.beat = ebeat;
        rd_sel = 2'(sel);
        sb.push_back(e);
        step();
        e = sb.pop_front();
        case (e.id)
            0: begin
                check("rd_cnt_a", 64'(a_rd_cnt), 64'(e.cnt));
                check("rd_beat_a", 64'(a_rd_beat), 64'(e.beat));
            end
            1: begin
                check("rd_cnt_b", 64'(b_rd_cnt), 64'(e.cnt));
                check("rd_beat_b", 64'(b_rd_beat), 64'(e.beat));
            end
            default: begin
                check("rd_cnt_c", 64'(c_rd_cnt), 64'(e.cnt));
                check("rd_beat_c", 64'(c_rd_beat), 64'(e.beat));
            end
        endcase
    endtask

    initial begin
        tbl[0] = '{4'b0001, 1};
        tbl[1] = '{4'b0011, 3};
        tbl[2] = '{4'b1010, 5};
        tbl[3] = '{4'b1111, 9};
        tbl[4] = '{4'b0100, 10};
        tbl[5] = '{4'b0000, 10};

        rst = 1'b1; sop_in = '0; vld_in = '0; clear = 1'b0; snap = 1'b0; rd_sel = '0;

        // Reset held while every input toggles.
        for (int i = 0; i < 3; i++) begin
            sop_in = 4'($urandom); vld_in = 4'($urandom);
            clear = 1'($urandom); snap = 1'($urandom); rd_sel = 2'($urandom);
            step();
            check("rst_rd_cnt", 64'(a_rd_cnt), 64'd0);
            check("rst_rd_beat", 64'(a_rd_beat), 64'd0);
            check("rst_total", 64'(a_total), 64'd0);
            check("rst_sat", 64'(a_sat), 64'd0);
            check("rst_snap_vld", 64'(a_snap_vld), 64'd0);
        end
        rst = 1'b0; sop_in = '0; vld_in = '0; clear = 1'b0; snap = 1'b0; rd_sel = '0;
        step();
        check("post_rst_snap_vld", 64'(a_snap_vld), 64'd0);
        check("post_rst_total", 64'(a_total), 64'd0);

        // Five pulses on port 2, then snapshot and read every port.
        for (int i = 0; i < 5; i++) pulse(4'b0100);
        check("p2_total", 64'(a_total), 64'd5);
        rd_sel = 2'd2;
        do_snap();
        check("snap_vld_set", 64'(a_snap_vld), 64'd1);
        for (int p = 0; p < 4; p++) do_read(0, p, (p == 2) ? 16'd5 : 16'd0, 16'd0);
        do_clear();
        check("clear_total", 64'(a_total), 64'd0);

        // All ports rising together: total steps 0 -> 4 on the second edge.
        sop_in = 4'b1111;
        step();
        check("all_rise_k", 64'(a_total), 64'd0);
        step();
        check("all_rise_k1", 64'(a_total), 64'd4);
        sop_in = 4'b0000;
        step();
        step();
        check("all_rise_hold", 64'(a_total), 64'd4);
        do_clear();

        // Table of pulse patterns with a per-port model.
        for (int p = 0; p < 4; p++) m[p] = 0;
        for (int i = 0; i < 6; i++) begin
            pulse(tbl[i].mask);
            for (int p = 0; p < 4; p++) m[p] += int'(tbl[i].mask[p]);
            check($sformatf("tbl_total_%0d", i), 64'(a_total), 64'(tbl[i].exp_total));
        end
        do_snap();
        for (int p = 0; p < 4; p++) do_read(0, p, 16'(m[p]), 16'd0);
        do_clear();

        // Read-and-clear with a coincident port-1 edge.
        for (int i = 0; i < 7; i++) pulse(4'b0010);
        check("p1_total7", 64'(a_total), 64'd7);
        sop_in = 4'b0010;
        step();
        snap = 1'b1; clear = 1'b1;
        step();
        snap = 1'b0; clear = 1'b0;
        check("rc_total0", 64'(a_total), 64'd0);
        do_read(0, 1, 16'd7, 16'd0);
        check("rc_level_held", 64'(a_total), 64'd0);
        sop_in = 4'b0000;
        step();
        step();
        check("rc_after_fall", 64'(a_total), 64'd0);
        do_snap();
        do_read(0, 1, 16'd0, 16'd0);

        // Reset in mid-operation overrides a simultaneous snap.
        pulse(4'b1000);
        check("mid_total1", 64'(a_total), 64'd1);
        rst = 1'b1; snap = 1'b1; sop_in = 4'b1000;
        step();
        rst = 1'b0; snap = 1'b0; sop_in = 4'b0000;
        check("mid_rst_snap_vld", 64'(a_snap_vld), 64'd0);
        check("mid_rst_total", 64'(a_total), 64'd0);
        step();
        check("mid_rst_total_b", 64'(a_total), 64'd0);

        // CNT_WIDTH=4 saturation on port 0.
        do_reset();
        for (int i = 0; i < 14; i++) pulse(4'b0001);
        check("b_sat14", 64'(b_sat), 64'd0);
        check("b_total14", 64'(b_total), 64'd14);
        for (int i = 0; i < 3; i++) pulse(4'b0001);
        check("b_total17", 64'(b_total), 64'd17);
        check("b_sat17", 64'(b_sat), 64'd1);
        do_snap();
        do_read(1, 0, 16'd15, 16'd0);
        do_clear();
        check("b_clr_total", 64'(b_total), 64'd0);
        check("b_clr_sat", 64'(b_sat), 64'd0);
        do_snap();
        do_read(1, 0, 16'd0, 16'd0);

        // EDGE_MODE=1: long high level counts only on its fall; beats ride along.
        do_reset();
        sop_in = 4'b0001; vld_in = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("c_high_%0d", i), 64'(c_total), 64'd0);
        end
        sop_in = 4'b0000; vld_in = 4'b0000;
        step();
        check("c_fall_k", 64'(c_total), 64'd0);
        step();
        check("c_fall_k1", 64'(c_total), 64'd1);
        do_snap();
        do_read(2, 0, 16'd1, BEAT_EXP);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
